// File: rtl/cray_scalar_pkg.sv
// cray_scalar_pkg: shared widths, latency and opcodes for the scalar add pipeline
package cray_scalar_pkg;
    localparam int WORD_W       = 64;
    localparam int S_ADDR_W     = 3;
    localparam int SADD_LATENCY = 3;
    localparam logic [6:0] OP_SADD = 7'o060;
    localparam logic [6:0] OP_SSUB = 7'o061;
    function automatic logic is_sadd_op(input logic [6:0] op);
        return (op == OP_SADD) || (op == OP_SSUB);
    endfunction
endpackage

// File: rtl/sreg_reservation.sv
// sreg_reservation: S-register reservation bitmap with one set port, one clear port
// Ports: i_set/i_set_addr mark a destination busy, i_clr/i_clr_addr release it,
//        i_chk_{i,j,k} are looked up combinationally into o_res_{i,j,k}; o_busy = any bit set.
module sreg_reservation
    import cray_scalar_pkg::*;
#(
    parameter int AW = S_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_chk_i,
    input  logic [AW-1:0] i_chk_j,
    input  logic [AW-1:0] i_chk_k,
    output logic          o_res_i,
    output logic          o_res_j,
    output logic          o_res_k,
    output logic          o_busy
);
    localparam int N = 1 << AW;
    logic [N-1:0] res_q, res_d;
    // set and clear of different bits on one edge are both honoured
    always_comb res_d = (res_q & ~({{(N-1){1'b0}}, i_clr} << i_clr_addr))
                      | ({{(N-1){1'b0}}, i_set} << i_set_addr);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
    assign o_res_i = res_q[i_chk_i];
    assign o_res_j = res_q[i_chk_j];
    assign o_res_k = res_q[i_chk_k];
    assign o_busy  = |res_q;
endmodule

// File: rtl/scalar_add_issue.sv
// scalar_add_issue: issue/writeback control for the 060/061 scalar add unit
// Ports: i_issue_* request (opcode, Si/Sj/Sk) handshaked by o_issue_rdy, o_illegal flags bad opcodes;
//        o_s{j,k}_addr / i_s{j,k}_data read the S file; o_instr/o_sj/o_sk feed the add unit;
//        o_wb_* write i_result back LATENCY clocks after capture; o_busy = any reservation.
module scalar_add_issue
    import cray_scalar_pkg::*;
#(
    parameter int WORD_W   = cray_scalar_pkg::WORD_W,
    parameter int S_ADDR_W = cray_scalar_pkg::S_ADDR_W,
    parameter int LATENCY  = SADD_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_issue_vld,
    output logic                o_issue_rdy,
    output logic                o_illegal,
    input  logic [6:0]          i_instr,
    input  logic [S_ADDR_W-1:0] i_i,
    input  logic [S_ADDR_W-1:0] i_j,
    input  logic [S_ADDR_W-1:0] i_k,
    output logic [S_ADDR_W-1:0] o_sj_addr,
    output logic [S_ADDR_W-1:0] o_sk_addr,
    input  logic [WORD_W-1:0]   i_sj_data,
    input  logic [WORD_W-1:0]   i_sk_data,
    output logic [6:0]          o_instr,
    output logic [WORD_W-1:0]   o_sj,
    output logic [WORD_W-1:0]   o_sk,
    input  logic [WORD_W-1:0]   i_result,
    output logic                o_wb_vld,
    output logic [S_ADDR_W-1:0] o_wb_addr,
    output logic [WORD_W-1:0]   o_wb_data,
    output logic                o_busy
);
    logic                legal, accept, res_i, res_j, res_k;
    logic [6:0]          instr_q, instr_d;
    logic [WORD_W-1:0]   sj_q, sj_d, sk_q, sk_d;
    logic [LATENCY:0]    tag_vld_q, tag_vld_d;
    logic [S_ADDR_W-1:0] tag_addr_q [LATENCY+1];

    sreg_reservation #(.AW(S_ADDR_W)) u_res (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (accept),
        .i_set_addr (i_i),
        .i_clr      (tag_vld_q[LATENCY]),
        .i_clr_addr (tag_addr_q[LATENCY]),
        .i_chk_i    (i_i),
        .i_chk_j    (i_j),
        .i_chk_k    (i_k),
        .o_res_i    (res_i),
        .o_res_j    (res_j),
        .o_res_k    (res_k),
        .o_busy     (o_busy)
    );

    // S0 as Sj reads as zero, so a reservation on register 0 never blocks j
    always_comb begin
        legal       = is_sadd_op(i_instr);
        o_issue_rdy = legal && !res_i && !res_k && !((i_j != '0) && res_j);
        o_illegal   = i_issue_vld && !legal;
        accept      = i_issue_vld && o_issue_rdy;
        instr_d     = accept ? i_instr : instr_q;
        sj_d        = accept ? ((i_j == '0) ? '0 : i_sj_data) : sj_q;
        sk_d        = accept ? i_sk_data : sk_q;
        tag_vld_d   = {tag_vld_q[LATENCY-1:0], accept};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            instr_q   <= '0;
            sj_q      <= '0;
            sk_q      <= '0;
            tag_vld_q <= '0;
        end else begin
            instr_q   <= instr_d;
            sj_q      <= sj_d;
            sk_q      <= sk_d;
            tag_vld_q <= tag_vld_d;
        end

    // destination tags need no reset: only the valid bits qualify them
    always_ff @(posedge clk) begin
        tag_addr_q[0] <= i_i;
        for (int s = 1; s <= LATENCY; s++) tag_addr_q[s] <= tag_addr_q[s-1];
    end

    assign o_sj_addr = i_j;
    assign o_sk_addr = i_k;
    assign o_instr   = instr_q;
    assign o_sj      = sj_q;
    assign o_sk      = sk_q;
    assign o_wb_vld  = tag_vld_q[LATENCY];
    assign o_wb_addr = tag_addr_q[LATENCY];
    assign o_wb_data = i_result;
endmodule

// File: doc/scalar_add_issue.md
Name: scalar_add_issue

Overview:
Issue and writeback controller on the initiator side of the 64-bit scalar add pipeline, which has a 3-clock functional time. It accepts 060 (Si = Sj+Sk) and 061 (Si = Sj−Sk) requests and reads Sj/Sk from the S register file. It drives the operand and opcode bus into the add unit and tracks in-flight destinations with a shift pipeline. It applies Cray-style S-register reservations so that dependent instructions stall, and produces the writeback strobe when the result emerges.

Parameters:
WORD_W, 64, operand/result width
S_ADDR_W, 3, S register address width (8 registers)
LATENCY, 3, add-unit clocks from operand capture edge to o_result valid

Ports:
clk  in  1  system clock (single domain)
rst_n  in  1  asynchronous, active-low reset
i_issue_vld  in  1  request valid
o_issue_rdy  out  1  request accepted on this edge when vld&rdy
o_illegal  out  1  combinational: vld with opcode not 060/061
i_instr  in  7  opcode (7'o060 or 7'o061)
i_i  in  S_ADDR_W  destination Si
i_j  in  S_ADDR_W  operand Sj (j=0 means zero operand)
i_k  in  S_ADDR_W  operand Sk
o_sj_addr  out  S_ADDR_W  combinational = i_j, register-file read port A
o_sk_addr  out  S_ADDR_W  combinational = i_k, read port B
i_sj_data  in  WORD_W  same-cycle read data A
i_sk_data  in  WORD_W  same-cycle read data B
o_instr  out  7  registered opcode to add unit
o_sj  out  WORD_W  registered Sj operand to add unit
o_sk  out  WORD_W  registered Sk operand to add unit
i_result  in  WORD_W  add-unit result
o_wb_vld  out  1  writeback strobe; register file writes on the next edge
o_wb_addr  out  S_ADDR_W  writeback register
o_wb_data  out  WORD_W  combinational = i_result
o_busy  out  1  any reservation set

Behaviour:
- Reset (async assert, sync release): reservation bitmap res=0, tag pipeline valid bits=0, o_instr=0, o_sj=0, o_sk=0. Outputs: o_wb_vld=0, o_busy=0. In-flight results are discarded; no writeback occurs after reset.
- Legal opcode: i_instr ∈ {7'o060, 7'o061}.
- o_issue_rdy = legal & !res[i] & !res[k] & !(j!=0 & res[j]).
- o_illegal = i_issue_vld & !legal. An illegal request never changes state.
- Accept on edge E when vld&rdy:
  - o_instr ← i_instr.
  - o_sj ← (j==0) ? 0 : i_sj_data.
  - o_sk ← i_sk_data.
  - res[i] set.
  - Tag stage 0 ← {1, i}.
- Without an accept, o_instr/o_sj/o_sk hold their values.
- Tag pipeline: LATENCY+1 stages of {valid, addr}, shifting every clock. o_wb_vld/o_wb_addr = stage LATENCY, asserted in the cycle between E+3 and E+4. The register file writes i_result at edge E+4, and res[addr] clears at the same edge E+4.
- Throughput: one accept per clock when there are no hazards.
- Hazards:
  - RAW on j/k and WAW on i stall until the reservation clears.
  - There is no bypass; a dependent request is accepted no earlier than E+5, reading the updated file.
- Simultaneous set and clear of the same bit cannot occur, because an issue to a reserved i is blocked. Set and clear of different bits on one edge are both honoured.
- o_busy = |res.
- The register-file write port is dedicated; there is no writeback backpressure.

Decomposition:
- Package cray_scalar_pkg: OP_SADD=7'o060, OP_SSUB=7'o061, WORD_W, S_ADDR_W, SADD_LATENCY.
- One sub-module, sreg_reservation: bitmap with set port, clear port, and three combinational check outputs (i, j, k).

Test Plan:
- Reset; S3=5, S4=7; issue 060 i=2 j=3 k=4 at edge E → o_instr=060, o_sj=5, o_sk=7 after E. o_wb_vld=1, addr=2, data=12 in cycle E+3..E+4. res[2]=0 after E+4.
- Issue 061 i=6 j=0 k=1 with S1=1 → o_sj=0; wb addr 6, data 64'hFFFF_FFFF_FFFF_FFFF.
- Three back-to-back independent issues to dest 1,2,3 → rdy held high, three consecutive wb strobes in order 1,2,3.
- Issue dest 5 at E; hold request reading k=5 → rdy=0 at edges E+1..E+4, accepted at E+5 using the written value. Repeat with dest=5 (WAW) → same stall.
- vld with i_instr=7'o062 → o_illegal=1, rdy=0, no res/tag change, no wb.
- Issue at E, assert rst_n low at E+2 and release → o_wb_vld never rises, o_busy=0, next legal request accepted immediately.
